alu_result_fifo: RTL and testbench
==================================

// Module: alu_result_fifo
// PURPOSE
//   Downstream capture buffer for the registered SHIFT_UNIT output (SHIFT_OUT/SHIFT_Flag).
//   - Queues each flagged result with its 2-bit ALU_FUN tag.
//   - Presents results first-word-fall-through to the consumer on a valid/ready handshake.
//   - The shift stage has no backpressure: writes arriving while full are dropped and
//     recorded in a sticky overflow flag.
// PARAMETERS
//   WIDTH  4  data width; matches SHIFT_UNIT WIDTH, data signed
//   DEPTH  4  entries; power of two, >= 2
//   FUN_W  2  tag width; carries the ALU_FUN that produced the result
// PORTS
//   CLK       in   1                  single clock, rising edge
//   RST       in   1                  synchronous reset, active-high
//   IN_DATA   in   WIDTH (signed)     result word; connects to SHIFT_OUT
//   IN_FUN    in   FUN_W              tag for IN_DATA; ALU_FUN delayed one cycle by the integrator
//   IN_Valid  in   1                  write strobe; connects to SHIFT_Flag
//   OUT_DATA  out  WIDTH (signed)     head entry data
//   OUT_FUN   out  FUN_W              head entry tag
//   OUT_Valid out  1                  head entry valid (= !EMPTY)
//   OUT_Ready in   1                  consumer accepts head this cycle
//   FULL      out  1                  COUNT == DEPTH
//   EMPTY     out  1                  COUNT == 0
//   COUNT     out  $clog2(DEPTH)+1    occupancy
//   OVF       out  1                  sticky: at least one write dropped
//   OVF_CLR   in   1                  clears OVF (and DROP_CNT when enabled)
// BEHAVIOUR
//   Reset (RST=1 at posedge): sets all of the following; memory contents are don't-care.
//     - wr_ptr=rd_ptr=0, COUNT=0, EMPTY=1, FULL=0, OVF=0
//     - OUT_Valid=0, OUT_DATA=0, OUT_FUN=0
//   Reset mid-stream: all queued entries are discarded; the first write after reset is the
//     first entry read out.
//   Pop:  pop  = OUT_Valid & OUT_Ready. rd_ptr advances mod DEPTH.
//   Push: push = IN_Valid & (!FULL | pop). Writes {IN_FUN, IN_DATA} at wr_ptr; wr_ptr
//     advances mod DEPTH.
//   COUNT next = COUNT + push - pop. FULL, EMPTY and OUT_Valid are derived from registered
//     COUNT (or equivalent registered flags).
//   FWFT output: OUT_DATA/OUT_FUN = mem[rd_ptr] when !EMPTY, forced 0 when EMPTY.
//   Latency: a write at edge N is visible on OUT_* after edge N. One-cycle write-to-read;
//     no combinational IN->OUT path.
//   Boundary cases:
//     - Full, IN_Valid=1, pop=1: push accepted, COUNT stays DEPTH, OVF unchanged.
//     - Full, IN_Valid=1, pop=0: entry dropped, OVF<=1, contents and pointers unchanged.
//     - Empty, IN_Valid=1, OUT_Ready=1: pop=0 (OUT_Valid low), push accepted, COUNT<=1.
//     - Empty, OUT_Ready=1, no push: nothing happens.
//     - Pointer wrap: wr_ptr/rd_ptr roll DEPTH-1 -> 0; ordering is strictly FIFO across
//       the wrap.
//   OVF:
//     - Set by any drop.
//     - OVF_CLR=1 clears it.
//     - Drop in the same cycle as OVF_CLR: set wins, OVF=1.
//   IN_DATA is stored verbatim; sign is preserved and no width conversion is performed.
// CONFIGURATION
//   ALU_RESULT_FIFO_DROP_CNT_EN
//     Defined:
//       - Adds output DROP_CNT [7:0]: count of dropped writes.
//       - Saturates at 8'hFF.
//       - Reset to 0 by RST; cleared by OVF_CLR.
//       - Drop in the same cycle as OVF_CLR: DROP_CNT<=1.
//     Undefined: the DROP_CNT port and counter are absent; all other behaviour is identical.
// TESTING
//   Reset: RST=1 for 2 cycles -> COUNT=0, EMPTY=1, FULL=0, OVF=0, OUT_Valid=0, OUT_DATA=0.
//   Ordered fill/drain: push 4'sd3,-4'sd2,4'sd7,-4'sd8 (tags 0..3), OUT_Ready=0 -> FULL=1,
//     COUNT=4; then OUT_Ready=1 -> reads 3,-2,7,-8 with tags 0,1,2,3; EMPTY=1 after 4 pops.
//   Overflow: full, push 4'sd5 with OUT_Ready=0 -> dropped, OVF=1, head still 3;
//     OVF_CLR=1 -> OVF=0.
//   Full push+pop: full, push 4'sd1 and OUT_Ready=1 -> COUNT=4, OVF=0, 1 read last.
//   Wrap and streaming: IN_Valid and OUT_Ready held high for 10 cycles, data 0..9 ->
//     COUNT<=1 throughout, outputs 0..9 in order, one cycle behind input.
//   Mid-operation reset: COUNT=3, RST=1 for 1 cycle -> EMPTY=1; next push 4'sd6 is read first.
//     With DROP_CNT_EN, 3 drops -> DROP_CNT=3; OVF_CLR -> 0.

Source files
------------

// File: rtl/alu_result_fifo.sv
// Capture FIFO for SHIFT_UNIT results, tagged with ALU_FUN; optional DROP_CNT via ALU_RESULT_FIFO_DROP_CNT_EN.
// Latency: one cycle from write to FWFT head; OUT_* driven only from registered state.
// Backpressure: none upstream; a write while full with no pop is dropped and sets sticky OVF.
module alu_result_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int FUN_W = 2
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic signed [WIDTH-1:0]   IN_DATA,
   input  logic        [FUN_W-1:0]   IN_FUN,
   input  logic                      IN_Valid,
   output logic signed [WIDTH-1:0]   OUT_DATA,
   output logic        [FUN_W-1:0]   OUT_FUN,
   output logic                      OUT_Valid,
   input  logic                      OUT_Ready,
   output logic                      FULL,
   output logic                      EMPTY,
   output logic [$clog2(DEPTH):0]    COUNT,
   output logic                      OVF,
   input  logic                      OVF_CLR
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
   ,
   output logic [7:0]                DROP_CNT
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic        [FUN_W-1:0] fun;
      logic signed [WIDTH-1:0] data;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            pop;
   logic            push;
   logic            drop;
   entry_t          head;

   assign EMPTY     = (COUNT == '0);
   assign FULL      = (COUNT == CNT_FULL);
   assign OUT_Valid = !EMPTY;

   assign pop  = OUT_Valid & OUT_Ready;
   assign push = IN_Valid & (!FULL | pop);
   assign drop = IN_Valid & FULL & !pop;

   assign head     = mem[rd_ptr];
   assign OUT_DATA = EMPTY ? '0 : head.data;
   assign OUT_FUN  = EMPTY ? '0 : head.fun;

   // Storage is deliberately unreset; EMPTY masks stale contents at the output.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= '{fun: IN_FUN, data: IN_DATA};
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         COUNT  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         COUNT <= COUNT + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   // A drop in the same cycle as a clear must still be reported.
   always_ff @(posedge CLK) begin
      if (RST) begin
         OVF <= 1'b0;
      end else if (drop) begin
         OVF <= 1'b1;
      end else if (OVF_CLR) begin
         OVF <= 1'b0;
      end
   end

`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         DROP_CNT <= 8'd0;
      end else if (drop) begin
         if (OVF_CLR) begin
            DROP_CNT <= 8'd1;
         end else if (DROP_CNT != 8'hFF) begin
            DROP_CNT <= DROP_CNT + 8'd1;
         end
      end else if (OVF_CLR) begin
         DROP_CNT <= 8'd0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: vector table plus a streaming/wrap sequence.
module tb_alu_result_fifo;

   logic              CLK;
   logic              RST;
   logic signed [3:0] IN_DATA;
   logic        [1:0] IN_FUN;
   logic              IN_Valid;
   logic signed [3:0] OUT_DATA;
   logic        [1:0] OUT_FUN;
   logic              OUT_Valid;
   logic              OUT_Ready;
   logic              FULL;
   logic              EMPTY;
   logic        [2:0] COUNT;
   logic              OVF;
   logic              OVF_CLR;
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
   logic        [7:0] DROP_CNT;
`endif

   int checks   = 0;
   int failures = 0;

   alu_result_fifo #(.WIDTH(4), .DEPTH(4), .FUN_W(2)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_DATA   (IN_DATA),
      .IN_FUN    (IN_FUN),
      .IN_Valid  (IN_Valid),
      .OUT_DATA  (OUT_DATA),
      .OUT_FUN   (OUT_FUN),
      .OUT_Valid (OUT_Valid),
      .OUT_Ready (OUT_Ready),
      .FULL      (FULL),
      .EMPTY     (EMPTY),
      .COUNT     (COUNT),
      .OVF       (OVF),
      .OVF_CLR   (OVF_CLR)
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
      ,
      .DROP_CNT  (DROP_CNT)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic              rst;
      logic              iv;
      logic signed [3:0] id;
      logic        [1:0] ifn;
      logic              rdy;
      logic              clr;
      logic        [2:0] e_cnt;
      logic              e_ovf;
      logic signed [3:0] e_dat;
      logic        [1:0] e_fun;
      logic        [7:0] e_drop;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(int rst, int iv, int id, int ifn, int rdy, int clr,
                               int cnt, int ovf, int dat, int fun, int drop);
      vec_t v;
      v.rst    = 1'(rst);
      v.iv     = 1'(iv);
      v.id     = 4'(id);
      v.ifn    = 2'(ifn);
      v.rdy    = 1'(rdy);
      v.clr    = 1'(clr);
      v.e_cnt  = 3'(cnt);
      v.e_ovf  = 1'(ovf);
      v.e_dat  = 4'(dat);
      v.e_fun  = 2'(fun);
      v.e_drop = 8'(drop);
      return v;
   endfunction

   task automatic chk(input string nm, input int row, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %0d expected %0d", nm, row, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic iv, input logic signed [3:0] id,
                        input logic [1:0] ifn, input logic rdy, input logic clr);
      @(negedge CLK);
      RST       = rst;
      IN_Valid  = iv;
      IN_DATA   = id;
      IN_FUN    = ifn;
      OUT_Ready = rdy;
      OVF_CLR   = clr;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      vec_t v;
      logic signed [3:0] e;
      RST = 1'b1; IN_Valid = 1'b0; IN_DATA = '0; IN_FUN = '0; OUT_Ready = 1'b0; OVF_CLR = 1'b0;

      //            rst iv  id fn rdy clr | cnt ovf dat fun drop
      vq.push_back(mk(1, 0,  0, 0, 0, 0,   0, 0,  0, 0, 0));
      vq.push_back(mk(1, 0,  0, 0, 0, 0,   0, 0,  0, 0, 0));
      vq.push_back(mk(0, 1,  3, 0, 0, 0,   1, 0,  3, 0, 0));
      vq.push_back(mk(0, 1, -2, 1, 0, 0,   2, 0,  3, 0, 0));
      vq.push_back(mk(0, 1,  7, 2, 0, 0,   3, 0,  3, 0, 0));
      vq.push_back(mk(0, 1, -8, 3, 0, 0,   4, 0,  3, 0, 0));
      vq.push_back(mk(0, 1,  5, 0, 0, 0,   4, 1,  3, 0, 1));  // drop while full
      vq.push_back(mk(0, 0,  0, 0, 0, 1,   4, 0,  3, 0, 0));
      vq.push_back(mk(0, 0,  0, 0, 1, 0,   3, 0, -2, 1, 0));
      vq.push_back(mk(0, 0,  0, 0, 1, 0,   2, 0,  7, 2, 0));
      vq.push_back(mk(0, 0,  0, 0, 1, 0,   1, 0, -8, 3, 0));
      vq.push_back(mk(0, 0,  0, 0, 1, 0,   0, 0,  0, 0, 0));
      vq.push_back(mk(0, 0,  0, 0, 1, 0,   0, 0,  0, 0, 0));
      vq.push_back(mk(0, 1,  4, 1, 1, 0,   1, 0,  4, 1, 0));  // push into empty with ready
      vq.push_back(mk(0, 1,  5, 2, 0, 0,   2, 0,  4, 1, 0));
      vq.push_back(mk(0, 1,  6, 3, 0, 0,   3, 0,  4, 1, 0));
      vq.push_back(mk(0, 1,  7, 0, 0, 0,   4, 0,  4, 1, 0));
      vq.push_back(mk(0, 1,  1, 1, 1, 0,   4, 0,  5, 2, 0));  // full push+pop
      vq.push_back(mk(0, 0,  0, 0, 1, 0,   3, 0,  6, 3, 0));
      vq.push_back(mk(0, 0,  0, 0, 1, 0,   2, 0,  7, 0, 0));
      vq.push_back(mk(0, 0,  0, 0, 1, 0,   1, 0,  1, 1, 0));
      vq.push_back(mk(0, 0,  0, 0, 1, 0,   0, 0,  0, 0, 0));
      vq.push_back(mk(0, 1, -1, 0, 0, 0,   1, 0, -1, 0, 0));
      vq.push_back(mk(0, 1, -3, 1, 0, 0,   2, 0, -1, 0, 0));
      vq.push_back(mk(0, 1,  2, 2, 0, 0,   3, 0, -1, 0, 0));
      vq.push_back(mk(0, 1, -7, 3, 0, 0,   4, 0, -1, 0, 0));
      vq.push_back(mk(0, 1,  3, 0, 0, 1,   4, 1, -1, 0, 1));  // drop beats clear
      vq.push_back(mk(0, 1,  3, 0, 0, 0,   4, 1, -1, 0, 2));
      vq.push_back(mk(0, 1,  3, 0, 0, 0,   4, 1, -1, 0, 3));
      vq.push_back(mk(0, 0,  0, 0, 0, 1,   4, 0, -1, 0, 0));
      vq.push_back(mk(0, 1,  3, 0, 0, 0,   4, 1, -1, 0, 1));
      vq.push_back(mk(0, 0,  0, 0, 1, 0,   3, 1, -3, 1, 1));
      vq.push_back(mk(1, 1,  5, 1, 0, 0,   0, 0,  0, 0, 0));  // mid-stream reset
      vq.push_back(mk(0, 1,  6, 2, 0, 0,   1, 0,  6, 2, 0));
      vq.push_back(mk(0, 0,  0, 0, 1, 0,   0, 0,  0, 0, 0));

      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         drive(v.rst, v.iv, v.id, v.ifn, v.rdy, v.clr);
         chk("COUNT",     i, int'(COUNT),     int'(v.e_cnt));
         chk("FULL",      i, int'(FULL),      int'(v.e_cnt == 3'd4));
         chk("EMPTY",     i, int'(EMPTY),     int'(v.e_cnt == 3'd0));
         chk("OUT_Valid", i, int'(OUT_Valid), int'(v.e_cnt != 3'd0));
         chk("OVF",       i, int'(OVF),       int'(v.e_ovf));
         chk("OUT_DATA",  i, int'(OUT_DATA),  int'(v.e_dat));
         chk("OUT_FUN",   i, int'(OUT_FUN),   int'(v.e_fun));
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
         chk("DROP_CNT",  i, int'(DROP_CNT),  int'(v.e_drop));
`endif
      end

      // Streaming across pointer wrap: each word appears on the head one edge after entry.
      for (int i = 0; i < 10; i++) begin
         e = 4'(i);
         drive(1'b0, 1'b1, e, 2'(i), 1'b1, 1'b0);
         chk("STREAM_COUNT", 100 + i, int'(COUNT),    1);
         chk("STREAM_DATA",  100 + i, int'(OUT_DATA), int'(e));
         chk("STREAM_FUN",   100 + i, int'(OUT_FUN),  i % 4);
         chk("STREAM_OVF",   100 + i, int'(OVF),      0);
      end
      drive(1'b0, 1'b0, 4'sd0, 2'd0, 1'b1, 1'b0);
      chk("STREAM_EMPTY", 110, int'(EMPTY), 1);
      chk("STREAM_DRAIN", 110, int'(COUNT), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
